// File: rtl/tm1638_responder_if.sv
// TM1638 three-wire bus: strobe/clock/data from the host, with the
// bidirectional DIO pin split into in/out/oe.
//   tm1638_strobe  - frame select, active low (host -> responder)
//   tm1638_clk     - serial clock (host -> responder)
//   tm1638_dio_in  - serial data (host -> responder)
//   tm1638_dio_out - serial data (responder -> host)
//   tm1638_dio_oe  - 1 = responder drives the DIO pin
interface tm1638_responder_if;
  logic tm1638_strobe;
  logic tm1638_clk;
  logic tm1638_dio_in;
  logic tm1638_dio_out;
  logic tm1638_dio_oe;

  modport master (
    output tm1638_strobe,
    output tm1638_clk,
    output tm1638_dio_in,
    input  tm1638_dio_out,
    input  tm1638_dio_oe
  );

  modport slave (
    input  tm1638_strobe,
    input  tm1638_clk,
    input  tm1638_dio_in,
    output tm1638_dio_out,
    output tm1638_dio_oe
  );
endinterface

// File: rtl/tm1638_responder.sv
// Device-side model of a TM1638: receives host frames, decodes data,
// display-control and address commands, keeps the 16-byte display RAM and
// returns the 4-byte key report on read commands. All bus inputs are
// synchronised into the system clock domain.
//   clk, n_rst     - system clock, asynchronous active-low reset
//   bus            - TM1638 bus (slave side)
//   keys           - live key states, 1 = pressed
//   display_ram    - byte n at [8n+7:8n]
//   display_on     - display-control bit 3
//   display_level  - display-control bits 2:0
//   wr_valid/wr_addr/wr_data - one-cycle pulse per RAM byte written
//   cmd_error      - one-cycle pulse on an unexpected byte
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  tm1638_responder_if.slave        bus,
  input  logic [7:0]               keys,
  output logic [127:0]             display_ram,
  output logic                     display_on,
  output logic [2:0]               display_level,
  output logic                     wr_valid,
  output logic [3:0]               wr_addr,
  output logic [7:0]               wr_data,
  output logic                     cmd_error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  // Report byte k carries key k in bit 0 and key k+4 in bit 4.
  function automatic logic [31:0] key_report(input logic [7:0] k);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      r[8*b]     = k[b];
      r[8*b + 4] = k[b + 4];
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic                   strobe_s;
  logic                   sclk_s;
  logic                   dio_s;
  logic                   sclk_q;
  logic                   sclk_rise;
  logic                   sclk_fall;

  // Synchronisers idle high so a reset release with an idle bus produces no edges.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe_sync <= '1;
      sclk_sync   <= '1;
      dio_sync    <= '1;
      sclk_q      <= 1'b1;
    end else begin
      strobe_sync[0] <= bus.tm1638_strobe;
      sclk_sync[0]   <= bus.tm1638_clk;
      dio_sync[0]    <= bus.tm1638_dio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strobe_sync[i] <= strobe_sync[i-1];
        sclk_sync[i]   <= sclk_sync[i-1];
        dio_sync[i]    <= dio_sync[i-1];
      end
      sclk_q <= sclk_s;
    end
  end

  assign strobe_s  = strobe_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign dio_s     = dio_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  logic [2:0]  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_reg;   // seven bits suffice: the 8th arrives as dio_s
  logic [3:0]  addr;
  logic        addr_fixed;
  logic [31:0] report;
  logic [5:0]  rd_cnt;      // bit 5 set once all 32 report bits are out
  logic        dio_out;
  logic        dio_oe;
  logic [7:0]  rx_byte;
  logic        byte_phase;
  logic        byte_done;

  // Bits arrive LSB first, so the newest bit enters at the top.
  assign rx_byte    = {dio_s, shift_reg};
  assign byte_phase = (state == ST_CMD) || (state == ST_DATA) || (state == ST_IGNORE);
  assign byte_done  = byte_phase && sclk_rise && (bit_cnt == 3'd7);

  // NOTE: display_ram is a visible output register bank, not a RAM macro,
  // so it is reset like any other flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      addr          <= '0;
      addr_fixed    <= 1'b0;
      report        <= '0;
      rd_cnt        <= '0;
      dio_out       <= 1'b1;
      dio_oe        <= 1'b0;
      display_ram   <= '0;
      display_on    <= 1'b0;
      display_level <= '0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      cmd_error     <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      cmd_error <= 1'b0;
      if (strobe_s) begin
        // Frame inactive: any partial byte is dropped silently.
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        shift_reg <= '0;
        rd_cnt    <= '0;
        dio_oe    <= 1'b0;
        dio_out   <= 1'b1;
      end else begin
        if (state == ST_IDLE) begin
          state <= ST_CMD;
        end
        if (byte_phase && sclk_rise) begin
          shift_reg <= rx_byte[7:1];
          bit_cnt   <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD: begin
              case (rx_byte[7:6])
                2'b01: begin
                  addr_fixed <= rx_byte[2];
                  if (rx_byte[1]) begin
                    report <= key_report(keys);
                    rd_cnt <= '0;
                    state  <= ST_READ;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                2'b10: begin
                  display_on    <= rx_byte[3];
                  display_level <= rx_byte[2:0];
                  state         <= ST_IGNORE;
                end
                2'b11: begin
                  addr  <= rx_byte[3:0];
                  state <= ST_DATA;
                end
                default: begin
                  cmd_error <= 1'b1;
                  state     <= ST_IGNORE;
                end
              endcase
            end
            ST_DATA: begin
              display_ram[{addr, 3'b000} +: 8] <= rx_byte;
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= rx_byte;
              if (!addr_fixed) begin
                addr <= addr + 4'd1;
              end
            end
            default: cmd_error <= 1'b1;
          endcase
        end
        // Read data changes on falling edges so it is stable at host rises.
        if ((state == ST_READ) && sclk_fall) begin
          if (!rd_cnt[5]) begin
            dio_oe  <= 1'b1;
            dio_out <= report[rd_cnt[4:0]];
            rd_cnt  <= rd_cnt + 6'd1;
          end else begin
            dio_oe  <= 1'b0;
            dio_out <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.tm1638_dio_out = dio_out;
  assign bus.tm1638_dio_oe  = dio_oe;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder. A host driver produces frames
// with randomised phase lengths; a frame-level model predicts, cycle by
// cycle, every write, error pulse, display-control change and DIO level,
// and one compare process checks the DUT against it on every clock.
`timescale 1ns/1ps
module tb_tm1638_responder;

  logic         clk;
  logic         n_rst;
  logic [7:0]   keys;
  logic [127:0] display_ram;
  logic         display_on;
  logic [2:0]   display_level;
  logic         wr_valid;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         cmd_error;

  tm1638_responder_if bus ();

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .bus           (bus),
    .keys          (keys),
    .display_ram   (display_ram),
    .display_on    (display_on),
    .display_level (display_level),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cmd_error     (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model (driver side) ----------------
  typedef enum int {M_IDLE, M_CMD, M_DATA, M_READ, M_IGNORE} mstate_t;

  mstate_t     m_state;
  int          m_cnt;
  logic [7:0]  m_byte;
  logic [3:0]  m_addr;
  logic        m_fixed;
  logic [31:0] m_report;
  int          m_rd_idx;

  // Expected effects keyed by the cycle they become visible.
  logic [11:0] wr_ev   [int];
  bit          err_ev  [int];
  logic [3:0]  disp_ev [int];
  logic [1:0]  dio_ev  [int];

  function automatic void model_reset();
    m_state  = M_IDLE;
    m_cnt    = 0;
    m_byte   = 8'h00;
    m_addr   = 4'h0;
    m_fixed  = 1'b0;
    m_report = 32'h0;
    m_rd_idx = 0;
  endfunction

  function automatic logic [31:0] report_of(input logic [7:0] k);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      r = r | (32'(k[b]) << (8 * b)) | (32'(k[b + 4]) << (8 * b + 4));
    end
    return r;
  endfunction

  // Visible effects appear 3 cycles after the driving cycle.
  function automatic void decode(input int te, input logic [7:0] b);
    case (m_state)
      M_CMD: begin
        if (b[7:6] == 2'b01) begin
          m_fixed = b[2];
          if (b[1]) begin
            m_report = report_of(keys);
            m_rd_idx = 0;
            m_state  = M_READ;
          end else begin
            m_state = M_IGNORE;
          end
        end else if (b[7:6] == 2'b10) begin
          disp_ev[te] = b[3:0];
          m_state = M_IGNORE;
        end else if (b[7:6] == 2'b11) begin
          m_addr  = b[3:0];
          m_state = M_DATA;
        end else begin
          err_ev[te] = 1'b1;
          m_state = M_IGNORE;
        end
      end
      M_DATA: begin
        wr_ev[te] = {m_addr, b};
        if (!m_fixed) m_addr = 4'((int'(m_addr) + 1) % 16);
      end
      default: err_ev[te] = 1'b1;
    endcase
  endfunction

  function automatic void model_rise(input int t, input logic b);
    if (m_state == M_CMD || m_state == M_DATA || m_state == M_IGNORE) begin
      m_byte[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 8) begin
        decode(t + 3, m_byte);
        m_cnt  = 0;
        m_byte = 8'h00;
      end
    end
  endfunction

  function automatic void model_fall(input int t);
    if (m_state == M_READ) begin
      if (m_rd_idx < 32) dio_ev[t + 3] = {1'b1, m_report[m_rd_idx]};
      else               dio_ev[t + 3] = 2'b01;
      m_rd_idx++;
    end
  endfunction

  // ---------------- compare process ----------------
  logic [7:0] m_ram [16];
  logic       m_on;
  logic [2:0] m_level;
  logic       e_oe;
  logic       e_out;
  int         wr_seen  = 0;
  int         err_seen = 0;

  always @(negedge clk) begin : compare
    logic [127:0] exp_ram;
    logic         exp_wr;
    logic         exp_err;
    logic [11:0]  wr_e;
    exp_wr  = 1'b0;
    exp_err = 1'b0;
    if (!n_rst) begin
      foreach (m_ram[i]) m_ram[i] = 8'h00;
      m_on    = 1'b0;
      m_level = 3'd0;
      e_oe    = 1'b0;
      e_out   = 1'b1;
      wr_ev.delete();
      err_ev.delete();
      disp_ev.delete();
      dio_ev.delete();
      check("rst_dio_out", bus.tm1638_dio_out, 1'b1);
      check("rst_wr_addr", wr_addr, 4'h0);
      check("rst_wr_data", wr_data, 8'h00);
    end else begin
      if (wr_ev.exists(cyc)) begin
        exp_wr = 1'b1;
        wr_e   = wr_ev[cyc];
        wr_ev.delete(cyc);
        m_ram[wr_e[11:8]] = wr_e[7:0];
        check("wr_addr", wr_addr, wr_e[11:8]);
        check("wr_data", wr_data, wr_e[7:0]);
      end
      if (err_ev.exists(cyc)) begin
        exp_err = 1'b1;
        err_ev.delete(cyc);
      end
      if (disp_ev.exists(cyc)) begin
        {m_on, m_level} = disp_ev[cyc];
        disp_ev.delete(cyc);
      end
      if (dio_ev.exists(cyc)) begin
        {e_oe, e_out} = dio_ev[cyc];
        dio_ev.delete(cyc);
      end
      if (e_oe) check("dio_out", bus.tm1638_dio_out, e_out);
    end
    for (int i = 0; i < 16; i++) exp_ram[8*i +: 8] = m_ram[i];
    check("wr_valid", wr_valid, exp_wr);
    check("cmd_error", cmd_error, exp_err);
    check("display_ram", display_ram, exp_ram);
    check("display_on", display_on, m_on);
    check("display_level", display_level, m_level);
    check("dio_oe", bus.tm1638_dio_oe, e_oe);
    if (wr_valid)  wr_seen++;
    if (cmd_error) err_seen++;
  end

  // ---------------- host driver ----------------
  logic [7:0] frame_q [$];
  bit         toggle_keys;

  task automatic set_idle();
    bus.tm1638_strobe = 1'b1;
    bus.tm1638_clk    = 1'b1;
    bus.tm1638_dio_in = 1'b1;
  endtask

  task automatic strobe_low();
    @(negedge clk);
    bus.tm1638_strobe = 1'b0;
    m_state = M_CMD;
    m_cnt   = 0;
    m_byte  = 8'h00;
    repeat (2 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic strobe_high();
    @(negedge clk);
    bus.tm1638_strobe = 1'b1;
    bus.tm1638_dio_in = 1'b1;
    m_state = M_IDLE;
    m_cnt   = 0;
    m_byte  = 8'h00;
    dio_ev[cyc + 3] = 2'b01;
    repeat (2 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // Low phase >= 4 clk so the host samples settled read data before rising.
  task automatic send_bit(input logic b, output logic sampled);
    int lo;
    int hi;
    lo = 4 + int'($urandom_range(0, 2));
    hi = 3 + int'($urandom_range(0, 2));
    @(negedge clk);
    bus.tm1638_clk    = 1'b0;
    bus.tm1638_dio_in = b;
    model_fall(cyc);
    repeat (lo) @(negedge clk);
    sampled = bus.tm1638_dio_out;
    bus.tm1638_clk = 1'b1;
    model_rise(cyc, b);
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic clock_frame(input int partial, input int rd_bits, output logic [31:0] word);
    logic s;
    word = 32'h0;
    foreach (frame_q[i]) begin
      for (int j = 0; j < 8; j++) send_bit(frame_q[i][j], s);
    end
    for (int j = 0; j < partial; j++) send_bit(1'($urandom_range(0, 1)), s);
    for (int j = 0; j < rd_bits; j++) begin
      send_bit(1'b1, s);
      if (j < 32) word[j] = s;
      if (toggle_keys && j == 10) keys = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int partial, input int rd_bits, output logic [31:0] word);
    strobe_low();
    clock_frame(partial, rd_bits, word);
    strobe_high();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0]  word;
  logic [127:0] ram_before;
  int           wr0;
  int           err0;
  logic         s_dummy;

  initial begin
    n_rst = 1'b0;
    keys  = 8'h00;
    toggle_keys = 1'b0;
    set_idle();
    model_reset();
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset asserted in the middle of a frame, with the bus toggling.
    strobe_low();
    for (int j = 0; j < 5; j++) send_bit(1'b1, s_dummy);
    #2 n_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.tm1638_strobe = 1'($urandom_range(0, 1));
      bus.tm1638_clk    = 1'($urandom_range(0, 1));
      bus.tm1638_dio_in = 1'($urandom_range(0, 1));
      keys = 8'($urandom);
    end
    @(negedge clk);
    set_idle();
    keys = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("lit_rst_ram", display_ram, 128'h0);
    check("lit_rst_oe", bus.tm1638_dio_oe, 1'b0);
    check("lit_rst_wr_valid", wr_valid, 1'b0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    frame_q = {8'h8F};
    send_frame(0, 0, word);
    check("lit_on_8f", display_on, 1'b1);
    check("lit_level_8f", display_level, 3'd7);

    // Auto-increment writes.
    wr0 = wr_seen; err0 = err_seen;
    frame_q = {8'h40};             send_frame(0, 0, word);
    frame_q = {8'hC0, 8'h3F, 8'h06}; send_frame(0, 0, word);
    check("lit_auto_wr_count", wr_seen - wr0, 2);
    check("lit_auto_err_count", err_seen - err0, 0);
    check("lit_auto_ram", display_ram[15:0], 16'h063F);

    // Fixed mode, then auto-increment wrap at 0xF.
    frame_q = {8'h44};               send_frame(0, 0, word);
    frame_q = {8'hCF, 8'hAA, 8'h55}; send_frame(0, 0, word);
    check("lit_fixed_ram", display_ram[127:120], 8'h55);
    frame_q = {8'h40};               send_frame(0, 0, word);
    frame_q = {8'hCF, 8'h11, 8'h22}; send_frame(0, 0, word);
    check("lit_wrap_ram_f", display_ram[127:120], 8'h11);
    check("lit_wrap_ram_0", display_ram[7:0], 8'h22);

    // Key reads; 33 host clocks so the 33rd fall releases DIO.
    keys = 8'h11;
    frame_q = {8'h42}; send_frame(0, 33, word);
    check("lit_read_11", word, 32'h0000_0011);
    keys = 8'h82; toggle_keys = 1'b1;
    frame_q = {8'h42}; send_frame(0, 33, word);
    check("lit_read_82", word, 32'h1000_0100);
    toggle_keys = 1'b0;

    // Display control followed by a stray byte, then a 00xx command.
    ram_before = display_ram;
    err0 = err_seen;
    frame_q = {8'h8A, 8'h55}; send_frame(0, 0, word);
    check("lit_level_8a", display_level, 3'd2);
    check("lit_err_8a", err_seen - err0, 1);
    check("lit_ram_unchanged", display_ram, ram_before);
    err0 = err_seen;
    frame_q = {8'h20}; send_frame(0, 0, word);
    check("lit_err_20", err_seen - err0, 1);

    // Abort mid data byte, then a clean write to address 3.
    wr0 = wr_seen;
    frame_q = {8'hC3}; send_frame(5, 0, word);
    check("lit_abort_no_wr", wr_seen - wr0, 0);
    frame_q = {8'hC3, 8'h77}; send_frame(0, 0, word);
    check("lit_abort_ram3", display_ram[31:24], 8'h77);

    // Abort a read after 10 bits: DIO released within 3 clk of strobe high.
    keys = 8'hFF;
    strobe_low();
    frame_q = {8'h42};
    clock_frame(0, 10, word);
    check("lit_abort_read_oe_before", bus.tm1638_dio_oe, 1'b1);
    @(negedge clk);
    bus.tm1638_strobe = 1'b1;
    m_state = M_IDLE;
    m_cnt   = 0;
    dio_ev[cyc + 3] = 2'b01;
    repeat (3) @(negedge clk);
    check("lit_abort_read_oe", bus.tm1638_dio_oe, 1'b0);

    // Randomised frames checked against the model.
    for (int f = 0; f < 80; f++) begin
      logic [7:0] cmd;
      int kind;
      int partial;
      int rdb;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       cmd = {2'b01, 6'($urandom)};
        1:       cmd = {2'b10, 6'($urandom)};
        5:       cmd = {2'b00, 6'($urandom)};
        default: cmd = {2'b11, 6'($urandom)};
      endcase
      frame_q = {cmd};
      partial = 0;
      rdb     = 0;
      if (cmd[7:6] == 2'b01 && cmd[1]) begin
        rdb = int'($urandom_range(20, 40));
      end else begin
        repeat ($urandom_range(0, 3)) frame_q.push_back(8'($urandom));
        if ($urandom_range(0, 3) == 0) partial = int'($urandom_range(1, 7));
      end
      keys = 8'($urandom);
      toggle_keys = ($urandom_range(0, 1) == 1);
      send_frame(partial, rdb, word);
      if (rdb >= 32) check("rand_read_word", word, m_report);
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: stopped at cycle %0d, expected finish before 80000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

Device-side (responder) end of the TM1638 three-wire serial protocol: a synchronous model of the TM1638 chip that accepts frames from the existing TM1638 driver (strobe/clock/data), decodes data, address and display-control commands, maintains the 16-byte display RAM, and returns the 4-byte key-scan report on read commands. Used as a loop-back target on the board and as the bus-functional responder in driver testbenches. Runs on the system clock. The bidirectional pin is split into in/out/oe at the top level.

## Interface

Parameters:
- SYNC_STAGES, 2, synchroniser depth on strobe/clk/dio inputs; all latencies below are for 2.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- tm1638_strobe  in  1  frame select, active low
- tm1638_clk  in  1  serial clock from host
- tm1638_dio_in  in  1  serial data from host
- tm1638_dio_out  out  1  serial data to host
- tm1638_dio_oe  out  1  1 = responder drives the DIO pin
- keys  in  8  live key states, 1 = pressed
- display_ram  out  128  byte n at [8n+7:8n], n = 0..15
- display_on  out  1  display-control bit 3
- display_level  out  3  display-control bits 2:0
- wr_valid  out  1  one-cycle pulse per RAM byte written
- wr_addr  out  4  address of the write
- wr_data  out  8  data of the write
- cmd_error  out  1  one-cycle pulse on an unexpected byte

## Operation

- Inputs pass through SYNC_STAGES flops. Rising and falling edges of tm1638_clk are detected on the synchronised copies. DIO is synchronised with identical depth so sampling stays aligned.
- A frame is active while the synchronised strobe is low. Strobe high clears the bit counter and shift register, clears the frame state and read mode, and deasserts dio_oe.
- Bits are LSB first, sampled on sclk rising edges. The 3-bit counter completes a byte on the 8th rise.
- Frame states are IDLE, CMD, DATA, READ and IGNORE. Strobe falling enters CMD. The first byte of a frame is decoded as:
  - 01xx_xxxx, data command: bit2 sets the address mode (1 = fixed, 0 = auto-increment), which is held across frames. If bit1 = 1, snapshot the keys into a 32-bit report and go to READ; otherwise go to IGNORE. Bit3 (test mode) is ignored.
  - 10xx_xxxx, display control: display_on = b[3], display_level = b[2:0]. Go to IGNORE.
  - 11xx_xxxx, address set: addr = b[3:0]. Go to DATA.
  - 00xx_xxxx: cmd_error pulse, go to IGNORE.
- DATA state: each completed byte writes RAM[addr] and pulses wr_valid/wr_addr/wr_data. In auto-increment mode addr then increments modulo 16 (0xF wraps to 0x0). In fixed mode addr is held.
- IGNORE state: every further complete byte pulses cmd_error and is discarded.
- Key report byte k (k = 0..3) = {3'b0, keys[k+4], 3'b0, keys[k]}. Bytes are sent 0→3, LSB first.
- READ state:
  - On each sclk falling edge, dio_oe = 1 and dio_out = the next report bit.
  - After 32 bits, the following falling edge sets dio_oe = 0 and dio_out = 1.
  - Host rising edges in READ are not decoded.
- Reset or strobe high mid-byte discards the partial byte. No write occurs and no error is flagged.

## Timing

- Reset values: display_ram = 0, display_on = 0, display_level = 0, address mode = auto-increment, addr = 0, dio_oe = 0, dio_out = 1, wr_valid = 0, wr_addr = 0, wr_data = 0, cmd_error = 0.
- Edge-detect latency is 2 clk from the first clk edge that samples the new sclk level.
- wr_valid, display_ram update, display-control update and cmd_error all occur in the cycle after detection, i.e. 3 clk after the raw 8th rising edge. display_ram changes in the same cycle wr_valid is high.
- dio_out/dio_oe update 3 clk after the raw sclk falling edge. The host must hold sclk low for at least 4 clk before sampling.
- Each sclk high and low phase, and the strobe-high gap, must be at least 3 clk. Violations are not detected.
- The key snapshot is taken in the same cycle the read command is decoded. Key changes during READ do not affect the report.
- The strobe-high abort takes effect 2 clk after the raw rise, with dio_oe = 0 in the next cycle.

## Test plan

- Reset: hold n_rst low mid-frame with toggling inputs -> every output at its reset value; after release, a fresh frame 0x8F -> display_on = 1, display_level = 7.
- Auto-increment write: frame 0x40, then frame 0xC0 0x3F 0x06 -> two wr_valid pulses (0, 0x3F) then (1, 0x06); display_ram[7:0] = 0x3F, [15:8] = 0x06; cmd_error never pulses.
- Fixed mode and wrap:
  - Frame 0x44, then 0xCF 0xAA 0x55 -> both writes to address 0xF; final display_ram[127:120] = 0x55.
  - Frame 0x40, then 0xCF 0x11 0x22 -> address 0xF = 0x11, address 0x0 = 0x22.
- Key read: keys = 8'h11, frame 0x42 plus 32 clocks -> host reads 0x11 00 00 00. keys = 8'h82 -> 0x00 01 00 10. Toggling keys mid-read leaves the bytes unchanged; dio_oe = 0 after the 33rd falling edge.
- Errors: frame 0x8A 0x55 -> display_level = 2, one cmd_error pulse, RAM unchanged. Frame 0x20 -> cmd_error pulse.
- Abort:
  - Strobe high after 5 bits of a data byte -> no wr_valid; the next frame 0xC3 0x77 writes address 3 = 0x77.
  - Strobe high after 10 read bits -> dio_oe = 0 within 3 clk.
